// File: rtl/ibex_pext_mult16.sv
// ibex_pext_mult16: signed 16x16 SIMD multiply / multiply-accumulate for Zpn halfword ops.
// Uses the multdiv en/valid handshake and saturates accumulate ops to 32 bits.
module ibex_pext_mult16 #(
   parameter bit DualMult = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [4:0]  zpn_operator_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
   input  logic [31:0] operand_c_i,
   output logic        valid_o,
   output logic [31:0] result_o,
   output logic        ov_o
);
   localparam logic [4:0] OP_SMBB16 = 5'd1,  OP_SMBT16 = 5'd2,  OP_SMTT16 = 5'd3;
   localparam logic [4:0] OP_KMDA   = 5'd4,  OP_KMXDA  = 5'd5,  OP_SMDS   = 5'd6;
   localparam logic [4:0] OP_SMDRS  = 5'd7,  OP_SMXDS  = 5'd8,  OP_KMABB  = 5'd9;
   localparam logic [4:0] OP_KMABT  = 5'd10, OP_KMATT  = 5'd11, OP_KMADA  = 5'd12;
   localparam logic [4:0] OP_KMAXDA = 5'd13, OP_KMADS  = 5'd14, OP_KMADRS = 5'd15;
   localparam logic [4:0] OP_KMAXDS = 5'd16, OP_KMSDA  = 5'd17, OP_KMSXDA = 5'd18;

   typedef enum logic [1:0] {S_IDLE, S_STEP1, S_DONE} state_e;

   state_e              r_state;
   logic signed [33:0]  r_acc;
   logic [7:0]          w_ctl;
   logic signed [15:0]  w_a0, w_b0;
   logic signed [31:0]  w_p0, w_p1;
   logic signed [33:0]  w_init, w_e0, w_e1, w_sum0, w_first, w_step;
   logic                w_sel1, w_ovf;

   // ctl = {legal, P0 a.hi, P0 b.hi, sub P0, sub P1, two products, use c, saturate};
   // P1 always uses the opposite halves of P0.
   always_comb begin
      w_ctl = 8'b0;
      case (zpn_operator_i)
         OP_SMBB16: w_ctl = 8'b1000_0000;
         OP_SMBT16: w_ctl = 8'b1010_0000;
         OP_SMTT16: w_ctl = 8'b1110_0000;
         OP_KMDA:   w_ctl = 8'b1110_0101;
         OP_KMXDA:  w_ctl = 8'b1100_0101;
         OP_SMDS:   w_ctl = 8'b1110_1100;
         OP_SMDRS:  w_ctl = 8'b1000_1100;
         OP_SMXDS:  w_ctl = 8'b1100_1100;
         OP_KMABB:  w_ctl = 8'b1000_0011;
         OP_KMABT:  w_ctl = 8'b1010_0011;
         OP_KMATT:  w_ctl = 8'b1110_0011;
         OP_KMADA:  w_ctl = 8'b1110_0111;
         OP_KMAXDA: w_ctl = 8'b1100_0111;
         OP_KMADS:  w_ctl = 8'b1110_1111;
         OP_KMADRS: w_ctl = 8'b1000_1111;
         OP_KMAXDS: w_ctl = 8'b1100_1111;
         OP_KMSDA:  w_ctl = 8'b1111_1111;
         OP_KMSXDA: w_ctl = 8'b1101_1111;
         default:   w_ctl = 8'b0;
      endcase
   end

   assign w_sel1 = (r_state == S_STEP1);
   assign w_a0   = (w_ctl[6] ^ w_sel1) ? operand_a_i[31:16] : operand_a_i[15:0];
   assign w_b0   = (w_ctl[5] ^ w_sel1) ? operand_b_i[31:16] : operand_b_i[15:0];
   assign w_p0   = w_a0 * w_b0;

   if (DualMult) begin : g_dual
      logic signed [15:0] w_a1, w_b1;
      assign w_a1 = w_ctl[6] ? operand_a_i[15:0] : operand_a_i[31:16];
      assign w_b1 = w_ctl[5] ? operand_b_i[15:0] : operand_b_i[31:16];
      assign w_p1 = w_a1 * w_b1;
   end else begin : g_single
      assign w_p1 = '0;
   end

   assign w_init  = w_ctl[1] ? {{2{operand_c_i[31]}}, operand_c_i} : '0;
   assign w_e0    = {{2{w_p0[31]}}, w_p0};
   assign w_e1    = {{2{w_p1[31]}}, w_p1};
   assign w_sum0  = w_ctl[4] ? w_init - w_e0 : w_init + w_e0;
   assign w_first = (DualMult && w_ctl[2]) ? (w_ctl[3] ? w_sum0 - w_e1 : w_sum0 + w_e1) : w_sum0;
   assign w_step  = w_ctl[3] ? r_acc - w_e0 : r_acc + w_e0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (en_i) begin
               r_acc   <= w_ctl[7] ? w_first : '0;
               r_state <= (w_ctl[7] && w_ctl[2] && !DualMult) ? S_STEP1 : S_DONE;
            end
            S_STEP1: begin
               r_acc   <= en_i ? w_step : '0;
               r_state <= en_i ? S_DONE : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Top three bits disagree when the value does not fit in 32 signed bits.
   assign w_ovf    = w_ctl[0] && !((&r_acc[33:31]) || !(|r_acc[33:31]));
   assign valid_o  = (r_state == S_DONE) && en_i;
   assign ov_o     = valid_o && w_ovf;
   assign result_o = !valid_o ? 32'h0 :
                     w_ovf ? (r_acc[33] ? 32'h8000_0000 : 32'h7FFF_FFFF) : r_acc[31:0];
endmodule

// File: tb/tb_ibex_pext_mult16.sv
// tb_ibex_pext_mult16: directed vectors for the halfword multiply unit, single- and dual-multiplier builds.
module tb_ibex_pext_mult16;
   localparam logic [4:0] OP_SMBB16 = 5'd1, OP_SMTT16 = 5'd3, OP_KMDA = 5'd4, OP_SMDS = 5'd6;
   localparam logic [4:0] OP_SMDRS = 5'd7, OP_KMABB = 5'd9, OP_KMADA = 5'd12;
   localparam logic [4:0] OP_KMAXDS = 5'd16, OP_KMSDA = 5'd17, OP_BAD = 5'd31;

   logic        clk = 0, rst_ni = 0, en_i = 0;
   logic [4:0]  op = '0;
   logic [31:0] a = '0, b = '0, c = '0;
   logic        v0, v1, o0, o1;
   logic [31:0] r0, r1;
   int          checks = 0, failures = 0;
   int          lat, lat1;
   logic [31:0] res, res1;
   logic        ovf, ovf1;

   ibex_pext_mult16 #(.DualMult(1'b0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .zpn_operator_i(op),
      .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
      .valid_o(v0), .result_o(r0), .ov_o(o0));

   ibex_pext_mult16 #(.DualMult(1'b1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .zpn_operator_i(op),
      .operand_a_i(a), .operand_b_i(b), .operand_c_i(c),
      .valid_o(v1), .result_o(r1), .ov_o(o1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic [4:0] o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] ic);
      @(negedge clk);
      op = o; a = ia; b = ib; c = ic; en_i = 1;
      lat = 0; lat1 = 0; res = '0; res1 = '0; ovf = 0; ovf1 = 0;
      for (int k = 1; k <= 8 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (v1 && lat1 == 0) begin lat1 = k; res1 = r1; ovf1 = o1; end
         if (v0) begin lat = k; res = r0; ovf = o0; end
      end
      en_i = 0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(v0), 0);
      chk("rst_result", r0, 0);
      chk("rst_ov", 32'(o0), 0);
      @(negedge clk) rst_ni = 1;

      run_op(OP_SMBB16, 32'h0003_FFFE, 32'h0005_0004, 0);
      chk("smbb_res", res, 32'hFFFF_FFF8); chk("smbb_ov", 32'(ovf), 0); chk("smbb_lat", 32'(lat), 1);

      run_op(OP_KMDA, 32'h8000_8000, 32'h8000_8000, 0);
      chk("kmda_res", res, 32'h7FFF_FFFF); chk("kmda_ov", 32'(ovf), 1); chk("kmda_lat", 32'(lat), 2);
      chk("kmda_dual_res", res1, 32'h7FFF_FFFF); chk("kmda_dual_ov", 32'(ovf1), 1);
      chk("kmda_dual_lat", 32'(lat1), 1);

      run_op(OP_KMSDA, 32'h0001_0001, 32'h0001_0001, 32'h8000_0000);
      chk("kmsda_res", res, 32'h8000_0000); chk("kmsda_ov", 32'(ovf), 1); chk("kmsda_lat", 32'(lat), 2);

      run_op(OP_SMDRS, 32'h0002_0003, 32'h0004_0005, 0);
      chk("smdrs_res", res, 32'h0000_0007); chk("smdrs_ov", 32'(ovf), 0); chk("smdrs_lat", 32'(lat), 2);
      chk("smdrs_dual_res", res1, 32'h0000_0007);

      @(negedge clk);
      op = OP_KMADA; a = 32'h0001_0001; b = 32'h0001_0001; c = 0; en_i = 1;
      @(posedge clk); #1;
      en_i = 0;
      @(posedge clk); #1;
      chk("flush_valid", 32'(v0), 0);
      run_op(OP_KMABB, 32'h0000_0003, 32'h0000_0004, 32'd10);
      chk("kmabb_res", res, 32'd22); chk("kmabb_ov", 32'(ovf), 0); chk("kmabb_lat", 32'(lat), 1);

      @(negedge clk);
      op = OP_KMDA; a = 32'h8000_8000; b = 32'h8000_8000; c = 0; en_i = 1;
      @(posedge clk); #2;
      rst_ni = 0; #1;
      chk("midrst_valid", 32'(v0), 0);
      @(posedge clk); #1;
      chk("midrst_valid2", 32'(v0), 0); chk("midrst_result", r0, 0); chk("midrst_ov", 32'(o0), 0);
      en_i = 0;
      @(negedge clk) rst_ni = 1;
      run_op(OP_SMDS, 32'h0005_0002, 32'h0003_0007, 0);
      chk("smds_res", res, 32'd1); chk("smds_ov", 32'(ovf), 0); chk("smds_lat", 32'(lat), 2);

      run_op(OP_BAD, 32'h1234_5678, 32'h1111_2222, 32'h7777_7777);
      chk("bad_res", res, 0); chk("bad_ov", 32'(ovf), 0); chk("bad_lat", 32'(lat), 1);

      run_op(OP_KMAXDS, 32'h0002_0003, 32'h0004_0005, 32'd100);
      chk("kmaxds_res", res, 32'd98); chk("kmaxds_ov", 32'(ovf), 0); chk("kmaxds_lat", 32'(lat), 2);

      run_op(OP_SMTT16, 32'hFFFF_0000, 32'h8000_0000, 0);
      chk("smtt_res", res, 32'h0000_8000); chk("smtt_ov", 32'(ovf), 0); chk("smtt_lat", 32'(lat), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
